// File: rtl/txn_pkg.sv
// txn_pkg: step codes, datapath FSM states and the rotate-left helper
package txn_pkg;
   localparam logic [2:0] STEP_AMT  = 3'b001;
   localparam logic [2:0] STEP_SIG  = 3'b010;
   localparam logic [2:0] STEP_MINE = 3'b011;
   localparam logic [2:0] STEP_FIN  = 3'b100;
   typedef enum logic [2:0] {S_IDLE, S_ARMED, S_AMT, S_SIG, S_MINE, S_FIN, S_DONE} state_t;
   // rotate the low w bits of x left by amt (amt < w <= 64)
   function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned amt, input int unsigned w);
      logic [63:0] m;
      m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return ((x << amt) | ((x & m) >> (w - amt))) & m;
   endfunction
endpackage

// File: rtl/txn_hash_core.sv
// txn_hash_core: combinational rotl/xor mixer shared by signature and mining steps
module txn_hash_core
   import txn_pkg::*;
#(
   parameter int KEY_W = 16
) (
   input  logic [KEY_W-1:0] x,
   input  logic [KEY_W-1:0] y,
   input  logic [1:0]       sh,
   output logic [KEY_W-1:0] h
);
   assign h = KEY_W'(rotl(64'(x), 32'(sh), KEY_W)) ^ y;
endmodule

// File: rtl/transaction_step_datapath.sv
// transaction_step_datapath: executes amount/signature/mining/settlement steps and pulses done_step.
// STEP_WATCHDOG_EN bounds mining to MINE_MAX_CYCLES candidates.
module transaction_step_datapath
   import txn_pkg::*;
#(
   parameter int VAL_W           = 16,
   parameter int KEY_W           = 16,
   parameter int NONCE_W         = 16,
   parameter int SIG_ROUNDS      = 4,
   parameter int DIFFICULTY      = 4,
   parameter int MINE_MAX_CYCLES = 1000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [2:0]         step,
   input  logic [2:0]         travel,
   input  logic [VAL_W-1:0]   amount,
   input  logic [VAL_W-1:0]   sender_balance,
   input  logic [VAL_W-1:0]   receiver_balance,
   input  logic [KEY_W-1:0]   sender_key,
   input  logic [KEY_W-1:0]   signature,
   output logic               done_step,
   output logic               busy,
   output logic               amount_ok,
   output logic               sig_ok,
   output logic               mined,
   output logic [NONCE_W-1:0] nonce,
   output logic [VAL_W-1:0]   new_sender_balance,
   output logic [VAL_W-1:0]   new_receiver_balance,
   output logic               tx_valid,
   output logic               tx_rejected
);
   localparam int RW = $clog2(SIG_ROUNDS + 1);
`ifdef STEP_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   state_t state, state_nx;
   logic [2:0] op;
   logic [RW-1:0] rnd;
   logic [KEY_W-1:0] h, mix_x, mix_y, mix;
   logic [1:0] mix_sh;
   logic hit, wd, last_rnd, arm_ok;
   assign mix_x = (state == S_MINE) ? signature ^ KEY_W'(nonce) : h;
   assign mix_y = (state == S_MINE) ? KEY_W'(amount) : sender_key;
   assign mix_sh = (state == S_MINE) ? 2'd3 : 2'd1;
   txn_hash_core #(.KEY_W(KEY_W)) u_hash (.x(mix_x), .y(mix_y), .sh(mix_sh), .h(mix));
   // DIFFICULTY==0 shifts everything out, so every candidate hits
   assign hit = (mix >> (KEY_W - DIFFICULTY)) == '0;
   assign wd = WD_EN && (nonce == NONCE_W'(MINE_MAX_CYCLES - 1));
   assign last_rnd = rnd == RW'(SIG_ROUNDS - 1);
   assign arm_ok = (travel != 3'b000) && (step == STEP_AMT || step == STEP_SIG || step == STEP_MINE);
   assign done_step = state == S_DONE;
   assign busy = state != S_IDLE && state != S_DONE;
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = arm_ok ? S_ARMED : (travel == 3'b000 && step == STEP_FIN) ? S_FIN : S_IDLE;
         S_ARMED: state_nx = (travel != 3'b000) ? S_ARMED : (op == STEP_AMT) ? S_AMT : (op == STEP_SIG) ? S_SIG : S_MINE;
         S_AMT:   state_nx = S_DONE;
         S_SIG:   state_nx = last_rnd ? S_DONE : S_SIG;
         S_MINE:  state_nx = (hit || wd) ? S_DONE : S_MINE;
         S_FIN:   state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         op <= 3'b000;
         rnd <= '0;
         h <= '0;
         amount_ok <= 1'b0;
         sig_ok <= 1'b0;
         mined <= 1'b0;
         nonce <= '0;
         new_sender_balance <= '0;
         new_receiver_balance <= '0;
         tx_valid <= 1'b0;
         tx_rejected <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (arm_ok) begin
               op <= step;
               if (step == STEP_AMT) begin
                  amount_ok <= 1'b0;
                  sig_ok <= 1'b0;
                  mined <= 1'b0;
                  nonce <= '0;
                  tx_valid <= 1'b0;
                  tx_rejected <= 1'b0;
               end
            end
            S_ARMED: if (travel == 3'b000) begin
               h <= sender_key ^ KEY_W'(amount);
               rnd <= '0;
               if (op == STEP_MINE) nonce <= '0;
            end
            S_AMT: amount_ok <= sender_balance >= amount;
            S_SIG: begin
               h <= mix;
               rnd <= rnd + 1'b1;
               if (last_rnd) sig_ok <= mix == signature;
            end
            S_MINE: if (hit) mined <= 1'b1; else if (!wd) nonce <= nonce + 1'b1;
            S_FIN: begin
               tx_valid <= amount_ok & sig_ok & mined;
               tx_rejected <= ~(amount_ok & sig_ok & mined);
               new_sender_balance <= (amount_ok & sig_ok & mined) ? sender_balance - amount : sender_balance;
               new_receiver_balance <= (amount_ok & sig_ok & mined) ? receiver_balance + amount : receiver_balance;
            end
            default: ;
         endcase
      end
   end
endmodule
